// File: rtl/seg7_countdown_display_if.sv
// Display-stage bundle: countdown value load strobe in, multiplexed 7-segment drive out.
// Master loads values and watches the display; slave is the display engine.
interface seg7_countdown_display_if #(
    parameter int TIMER_WIDTH = 4
);
    logic [TIMER_WIDTH-1:0] value;
    logic                   value_valid;
    logic [6:0]             seg;
    logic [1:0]             an;
    logic                   busy;

    modport master (
        output value,
        output value_valid,
        input  seg,
        input  an,
        input  busy
    );

    modport slave (
        input  value,
        input  value_valid,
        output seg,
        output an,
        output busy
    );
endinterface

// File: rtl/seg7_countdown_display.sv
// Binary countdown -> 2-digit BCD (sequential double-dabble) -> muxed active-low 7-segment drive.
// Define SEG_LEADING_ZERO_BLANK_EN to blank the tens digit when it is zero.
module seg7_countdown_display #(
    parameter int TIMER_WIDTH = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rstn,
    seg7_countdown_display_if.slave bus
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [14:0] dd_q, dd_d;            // {tens, ones, binary}
    logic [2:0]  iter_q, iter_d;
    logic [6:0]  pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;

    logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
    logic             sel_q, sel_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;

    logic [6:0]  value_ext;
    logic [6:0]  value_sat;
    logic [14:0] dd_adj;
    logic        start;
    logic [6:0]  start_val;
    logic [6:0]  ones_pat;
    logic [6:0]  tens_pat;

    function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    assign value_ext = 7'(bus.value);
    assign value_sat = (value_ext > 7'd99) ? 7'd99 : value_ext;

    // Add-3 correction on each BCD nibble before the shift.
    assign dd_adj[6:0] = dd_q[6:0];
    for (genvar gi = 0; gi < 2; gi++) begin : g_adj
        logic [3:0] nib;
        assign nib = dd_q[7 + 4*gi +: 4];
        assign dd_adj[7 + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end

    always_comb begin
        state_d    = state_q;
        dd_d       = dd_q;
        iter_d     = iter_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        start      = 1'b0;
        start_val  = value_sat;

        case (state_q)
            IDLE: begin
                if (bus.value_valid) start = 1'b1;
            end
            SHIFT: begin
                dd_d   = 15'({dd_adj, 1'b0});
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd6) state_d = LOAD;
                if (bus.value_valid) begin
                    pend_d     = value_sat;
                    pend_vld_d = 1'b1;
                end
            end
            LOAD: begin
                tens_d  = dd_q[14:11];
                ones_d  = dd_q[10:7];
                state_d = IDLE;
                // A strobe on this edge is newer than anything pending.
                if (bus.value_valid) begin
                    start = 1'b1;
                end else if (pend_vld_q) begin
                    start     = 1'b1;
                    start_val = pend_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d    = SHIFT;
            dd_d       = {8'd0, start_val};
            iter_d     = 3'd0;
            pend_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            dd_q       <= '0;
            iter_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            tens_q     <= '0;
            ones_q     <= '0;
        end else begin
            state_q    <= state_d;
            dd_q       <= dd_d;
            iter_q     <= iter_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
        end
    end

    assign ones_pat = seg7_encode(ones_q);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    assign tens_pat = (tens_q == 4'd0) ? 7'b1111111 : seg7_encode(tens_q);
`else
    assign tens_pat = seg7_encode(tens_q);
`endif

    always_comb begin
        refresh_cnt_d = refresh_cnt_q + 1'b1;
        sel_d         = sel_q;
        if (refresh_cnt_q == CNT_MAX) begin
            refresh_cnt_d = '0;
            sel_d         = ~sel_q;
        end
        seg_d = sel_q ? tens_pat : ones_pat;
        an_d  = sel_q ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            refresh_cnt_q <= '0;
            sel_q         <= 1'b0;
            seg_q         <= 7'b1111111;
            an_q          <= 2'b11;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            sel_q         <= sel_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign bus.seg  = seg_q;
    assign bus.an   = an_q;
    assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_seg7_countdown_display.sv
// Bench for seg7_countdown_display: timing-level model feeds a queue of expected digits,
// a negedge monitor checks seg/an/busy every cycle against it.
module tb_seg7_countdown_display;

    localparam int TW  = 7;
    localparam int DIV = 4;
    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef struct {
        int due;
        int tens;
        int ones;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    seg7_countdown_display_if #(.TIMER_WIDTH(TW)) dif ();

    seg7_countdown_display #(
        .TIMER_WIDTH(TW),
        .REFRESH_DIV(DIV)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (dif)
    );

    // Reference model: conversions take 8 edges, strobes while busy park in a
    // last-wins slot that starts the moment the current conversion finishes.
    exp_t exp_q[$];
    int   cyc = 0;
    int   end_cyc = 0;
    int   pend_val = 0;
    bit   active = 1'b0;
    bit   pend = 1'b0;

    task automatic start_conv(input int v);
        exp_t e;
        int   s;
        s      = (v > 99) ? 99 : v;
        e.due  = cyc + 8;
        e.tens = s / 10;
        e.ones = s % 10;
        exp_q.push_back(e);
        active  = 1'b1;
        end_cyc = cyc + 8;
        pend    = 1'b0;
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc    = 0;
            active = 1'b0;
            pend   = 1'b0;
            exp_q.delete();
        end else begin
            cyc++;
            if (active && cyc == end_cyc) active = 1'b0;
            if (dif.value_valid) begin
                if (!active) begin
                    start_conv(int'(dif.value));
                end else begin
                    pend     = 1'b1;
                    pend_val = int'(dif.value);
                end
            end
            if (!active && pend) start_conv(pend_val);
        end
    end

    // Monitor / scoreboard
    int checks = 0;
    int errors = 0;
    int shown_t = 0;
    int shown_o = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial begin
        exp_t       e;
        int         sel;
        logic [6:0] exp_seg;
        logic [6:0] tens_pat;
        forever begin
            @(negedge clk or negedge rstn);
            #1;
            if (!rstn || cyc == 0) begin
                shown_t = 0;
                shown_o = 0;
                check("reset_seg",  int'(dif.seg),  7'h7f);
                check("reset_an",   int'(dif.an),   3);
                check("reset_busy", int'(dif.busy), 0);
            end else begin
                while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                    e = exp_q.pop_front();
                    shown_t = e.tens;
                    shown_o = e.ones;
                    $display("cycle %0d: display now %0d%0d (loaded at cycle %0d)",
                             cyc, e.tens, e.ones, e.due);
                end
`ifdef SEG_LEADING_ZERO_BLANK_EN
                tens_pat = (shown_t == 0) ? 7'b1111111 : SEG_TAB[shown_t];
`else
                tens_pat = SEG_TAB[shown_t];
`endif
                sel     = ((cyc - 1) / DIV) % 2;
                exp_seg = (sel == 1) ? tens_pat : SEG_TAB[shown_o];
                check("an",   int'(dif.an),   (sel == 1) ? 1 : 2);
                check("seg",  int'(dif.seg),  int'(exp_seg));
                check("busy", int'(dif.busy), int'(active));
            end
        end
    end

    // Stimulus
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input int v);
        dif.value       = v[TW-1:0];
        dif.value_valid = 1'b1;
        @(negedge clk);
        dif.value_valid = 1'b0;
    endtask

    initial begin
        dif.value       = '0;
        dif.value_valid = 1'b0;
        idle(3);
        rstn = 1'b1;
        idle(12);

        strobe(9);    idle(14);
        strobe(127);  idle(14);
        strobe(100);  idle(14);
        strobe(42);   idle(2); strobe(15); idle(1); strobe(63); idle(16);
        strobe(12);   idle(7); strobe(34); idle(18);
        strobe(37);   idle(3);
        #2 rstn = 1'b0;
        idle(2);
        rstn = 1'b1;
        idle(12);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) strobe(int'($urandom_range(0, 127)));
            else idle(1);
        end
        idle(24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
